mem_access_stage: RTL

MEM pipeline stage of the 64-bit RISC-V pipeline, directly downstream of the EX/MEM register. It consumes EX/MEM outputs and performs the data-memory access over a req/ack handshake with variable latency. It freezes upstream stages while the access is outstanding. It registers the MEM/WB values (control, ALU result, load data, destination register) for the write-back stage.

---
 rtl/mem_stage_pkg.sv | 21 ++
 rtl/mem_wb_reg.sv | 23 ++
 rtl/mem_access_stage.sv | 122 ++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM stage: width defaults, FSM state and the MEM/WB bundle.
package mem_stage_pkg;

    localparam int unsigned XLEN_DEF = 64;
    localparam int unsigned RD_W_DEF = 5;

    typedef enum logic {
        IDLE,
        WAIT
    } memState_t;

    // Field widths follow the package defaults; the top uses the same defaults.
    typedef struct packed {
        logic                regWrite;
        logic                memToReg;
        logic [XLEN_DEF-1:0] aluOut;
        logic [XLEN_DEF-1:0] readData;
        logic [RD_W_DEF-1:0] rd;
    } memWb_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. A bubble clears the control bits and holds the data fields.
module mem_wb_reg
    import mem_stage_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   bubble,
    input  memWb_t d,
    output memWb_t q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (bubble) begin
            q.regWrite <= 1'b0;
            q.memToReg <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the 64-bit RISC-V pipeline: req/ack data-memory access, upstream stall, MEM/WB register.
// Optional access timeout with mem_err pulse is enabled by defining MEM_TIMEOUT_EN.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned XLEN        = XLEN_DEF,
    parameter int unsigned RD_W        = RD_W_DEF,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ex_reg_write,
    input  logic            ex_mem_to_reg,
    input  logic            ex_mem_write,
    input  logic            ex_mem_read,
    input  logic [XLEN-1:0] ex_alu_out,
    input  logic [XLEN-1:0] ex_store_data,
    input  logic [RD_W-1:0] ex_rd,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_ack,
    output logic            stall,
    output logic            wb_reg_write,
    output logic            wb_mem_to_reg,
    output logic [XLEN-1:0] wb_alu_out,
    output logic [XLEN-1:0] wb_read_data,
    output logic [RD_W-1:0] wb_rd,
    output logic            mem_err
);

    memState_t state;
    memState_t stateNext;
    logic      memOp;
    logic      pending;
    logic      accessDone;
    logic      loadDone;
    logic      timeoutHit;
    logic      bubble;
    memWb_t    wbNext;
    memWb_t    wbQ;

    assign memOp      = ex_mem_read | ex_mem_write;
    assign pending    = ~reset & (((state == IDLE) & memOp) | (state == WAIT));
    assign accessDone = pending & dmem_ack;
    // A simultaneous read+write is treated as a store, so load data is not captured.
    assign loadDone   = accessDone & ex_mem_read & ~ex_mem_write;
    assign bubble     = pending & ~dmem_ack;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] waitCnt;

    // The first req cycle is spent in IDLE, so WAIT sees TIMEOUT_CYC-1 cycles before abort.
    assign timeoutHit = ~reset & (state == WAIT) & ~dmem_ack
                        & (waitCnt == CNT_W'(TIMEOUT_CYC - 2));

    always_ff @(posedge clk) begin
        if (reset || state == IDLE) begin
            waitCnt <= '0;
        end else if (!dmem_ack) begin
            waitCnt <= waitCnt + 1'b1;
        end
    end

    assign mem_err = timeoutHit;
`else
    logic unusedTimeoutCfg;
    assign unusedTimeoutCfg = ^TIMEOUT_CYC;
    assign timeoutHit       = 1'b0;
    assign mem_err          = 1'b0;
`endif

    assign dmem_req   = pending;
    assign stall      = bubble & ~timeoutHit;
    assign dmem_we    = ex_mem_write;
    assign dmem_addr  = ex_alu_out;
    assign dmem_wdata = ex_store_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (pending && !dmem_ack) stateNext = WAIT;
            WAIT: if (dmem_ack || timeoutHit) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        wbNext          = wbQ;
        wbNext.regWrite = ex_reg_write & (ex_rd != '0);
        wbNext.memToReg = ex_mem_to_reg;
        wbNext.aluOut   = ex_alu_out;
        wbNext.rd       = ex_rd;
        wbNext.readData = loadDone ? dmem_rdata : wbQ.readData;
    end

    mem_wb_reg uMemWbReg (
        .clk   (clk),
        .reset (reset),
        .bubble(bubble),
        .d     (wbNext),
        .q     (wbQ)
    );

    assign wb_reg_write  = wbQ.regWrite;
    assign wb_mem_to_reg = wbQ.memToReg;
    assign wb_alu_out    = wbQ.aluOut;
    assign wb_read_data  = wbQ.readData;
    assign wb_rd         = wbQ.rd;

endmodule
